// File: rtl/tinyalu_pkg.sv
// Shared types, widths and the single-cycle ALU evaluation for the TinyALU responder.
package tinyalu_pkg;

    localparam int DATA_W   = 8;
    localparam int RESULT_W = 16;
    localparam int OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        HOLD = 2'b11
    } state_t;

    // add keeps its carry in bit 8, so it can never overflow the result
    function automatic logic [RESULT_W-1:0] alu_eval(
        input operation_t        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [RESULT_W-1:0] res;
        case (op)
            add_op:  res = {7'b000_0000, ({1'b0, a} + {1'b0, b})};
            and_op:  res = {8'h00, (a & b)};
            xor_op:  res = {8'h00, (a ^ b)};
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tinyalu_mult.sv
// Pipelined 8x8 unsigned multiplier; the product and its valid bit travel LATENCY register stages.
module tinyalu_mult
    import tinyalu_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                out_valid,
    output logic [RESULT_W-1:0] product
);

    logic [RESULT_W-1:0] prod_r [LATENCY];
    logic [LATENCY-1:0]  vld_r;

    // Product and valid shift chain; reset wipes any in-flight multiply
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                prod_r[i] <= 16'h0000;
            end
        end else begin
            vld_r[0]  <= in_valid;
            prod_r[0] <= {8'h00, a} * {8'h00, b};
            for (int i = 1; i < LATENCY; i++) begin
                vld_r[i]  <= vld_r[i-1];
                prod_r[i] <= prod_r[i-1];
            end
        end
    end

    assign out_valid = vld_r[LATENCY-1];
    assign product   = prod_r[LATENCY-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder: accepts an operation on start, returns result with a one-cycle done pulse.
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [OP_W-1:0]     op,
    input  logic                start,
    output logic                done,
    output logic [RESULT_W-1:0] result
);

    state_t              state_r;
    operation_t          op_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    operation_t          op_s;
    logic                mul_go_s;
    logic                mul_valid_s;
    logic [RESULT_W-1:0] mul_prod_s;
    logic [RESULT_W-1:0] alu_s;

    assign op_s = operation_t'(op);

    // Launch the multiplier on the same edge the FSM accepts a mul
    always_comb begin
        mul_go_s = 1'b0;
        if ((state_r == IDLE) && start && (op_s == mul_op)) begin
            mul_go_s = 1'b1;
        end else begin
            mul_go_s = 1'b0;
        end
    end

    // Single-cycle operations work from the captured operands only
    always_comb begin
        alu_s = alu_eval(op_r, a_r, b_r);
    end

    tinyalu_mult #(
        .LATENCY (MUL_LATENCY)
    ) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (mul_go_s),
        .a         (A),
        .b         (B),
        .out_valid (mul_valid_s),
        .product   (mul_prod_s)
    );

    // Control FSM with registered done/result; HOLD blocks re-trigger while start stays high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            op_r    <= no_op;
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            done    <= 1'b0;
            result  <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (op_s)
                            add_op, and_op, xor_op: begin
                                op_r    <= op_s;
                                a_r     <= A;
                                b_r     <= B;
                                state_r <= EXEC;
                            end
                            mul_op: begin
                                op_r    <= op_s;
                                a_r     <= A;
                                b_r     <= B;
                                state_r <= MUL;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    result  <= alu_s;
                    done    <= 1'b1;
                    state_r <= HOLD;
                end
                MUL: begin
                    if (mul_valid_s) begin
                        result  <= mul_prod_s;
                        done    <= 1'b1;
                        state_r <= HOLD;
                    end else begin
                        done    <= 1'b0;
                        state_r <= MUL;
                    end
                end
                HOLD: begin
                    done <= 1'b0;
                    if (!start) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_core.sv
// Directed self-checking bench for tinyalu_core with MUL_LATENCY=3.
module tb_tinyalu_core;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int checks;
    int errors;

    tinyalu_core #(
        .MUL_LATENCY (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        A = 8'h12; B = 8'h34; op = 3'b001; start = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL rst_done: got %b want 0", done); errors++; end
        checks++; if (result !== 16'h0000) begin $display("FAIL rst_result: got %h want 0000", result); errors++; end
        reset_n = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL rst_accept_done: got %b want 0", done); errors++; end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL rst_add_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h0046) begin $display("FAIL rst_add_result: got %h want 0046", result); errors++; end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL rst_add_pulse: got %b want 0", done); errors++; end
    endtask

    task automatic test_add_xor();
        A = 8'hFF; B = 8'hFF; op = 3'b001; start = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL add_early: got %b want 0", done); errors++; end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL add_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h01FE) begin $display("FAIL add_result: got %h want 01fe", result); errors++; end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL add_pulse: got %b want 0", done); errors++; end
        checks++; if (result !== 16'h01FE) begin $display("FAIL add_hold: got %h want 01fe", result); errors++; end
        A = 8'hF0; B = 8'h3C; op = 3'b011; start = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL xor_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h00CC) begin $display("FAIL xor_result: got %h want 00cc", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL mul_n0: got %b want 0", done); errors++; end
        A = 8'h01; B = 8'h02;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL mul_n1: got %b want 0", done); errors++; end
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL mul_n2: got %b want 0", done); errors++; end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL mul_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'hFE01) begin $display("FAIL mul_result: got %h want fe01", result); errors++; end
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL mul_pulse: got %b want 0", done); errors++; end
        checks++; if (result !== 16'hFE01) begin $display("FAIL mul_hold: got %h want fe01", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    task automatic test_noop();
        A = 8'h11; B = 8'h22; op = 3'b000; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL noop_done[%0d]: got %b want 0", i, done); errors++; end
        end
        op = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL op7_done[%0d]: got %b want 0", i, done); errors++; end
        end
        checks++; if (result !== 16'hFE01) begin $display("FAIL noop_result: got %h want fe01", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        A = 8'h01; B = 8'h01; op = 3'b001; start = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL hold_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h0002) begin $display("FAIL hold_result: got %h want 0002", result); errors++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL hold_retrig[%0d]: got %b want 0", i, done); errors++; end
        end
        start = 1'b0;
        tick();
        A = 8'hAA; B = 8'h0F; op = 3'b010; start = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL and_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h000A) begin $display("FAIL and_result: got %h want 000a", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    task automatic test_early_drop();
        A = 8'h05; B = 8'h06; op = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL drop_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h000B) begin $display("FAIL drop_result: got %h want 000b", result); errors++; end
        tick();
        A = 8'h55; B = 8'hFF; op = 3'b011; start = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL drop_next_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h00AA) begin $display("FAIL drop_next_result: got %h want 00aa", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        A = 8'h03; B = 8'h04; op = 3'b100; start = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin $display("FAIL midrst_done: got %b want 0", done); errors++; end
        checks++; if (result !== 16'h0000) begin $display("FAIL midrst_result: got %h want 0000", result); errors++; end
        start = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (done !== 1'b0) begin $display("FAIL midrst_nodone[%0d]: got %b want 0", i, done); errors++; end
        end
        A = 8'h01; B = 8'h02; op = 3'b001; start = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin $display("FAIL post_add_early: got %b want 0", done); errors++; end
        tick();
        checks++; if (done !== 1'b1) begin $display("FAIL post_add_done: got %b want 1", done); errors++; end
        checks++; if (result !== 16'h0003) begin $display("FAIL post_add_result: got %h want 0003", result); errors++; end
        start = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_xor();
        test_mul();
        test_noop();
        test_hold();
        test_early_drop();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
